// File: rtl/ahb_row_reader.sv
// +--------------------------------------------------------------------------+
// | ahb_row_reader : reads one row of 32-bit words over AHB as INCR bursts   |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module ahb_row_reader (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        row_start,
  input  logic [31:0] start_addr_r,
  input  logic [15:0] length,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic [2:0]  HBURST,
  output logic [2:0]  HSIZE,
  output logic        HWRITE,
  input  logic        HREADY,
  input  logic        HRESP,
  input  logic [31:0] HRDATA,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        addr_enable_r,
  output logic        row_done,
  output logic        busy,
  output logic        error
);

  localparam logic [1:0] C_TRANS_IDLE   = 2'b00;
  localparam logic [1:0] C_TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] C_TRANS_SEQ    = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_BURST     = 3'd1,
    S_LAST_DATA = 3'd2,
    S_DONE      = 3'd3,
    S_ERR       = 3'd4
  } state_t;

  state_t      state_q;
  logic [31:0] addr_q;
  logic [1:0]  htrans_q;
  logic [16:0] issued_q;
  logic [15:0] len_q;
  logic        pending_q;
  logic [31:0] rdata_q;
  logic        rdata_valid_q;
  logic        row_done_q;
  logic        error_q;

  logic [31:0] addr_d;
  logic [16:0] issued_d;
  logic        last_addr_d;
  logic        data_ok_d;
  logic        data_err_d;

  assign addr_d      = addr_q + 32'd4;
  assign issued_d    = issued_q + 17'd1;
  assign last_addr_d = (issued_d == {1'b0, len_q});
  assign data_ok_d   = pending_q && HREADY && !HRESP;
  assign data_err_d  = pending_q && HRESP;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q       <= S_IDLE;
      addr_q        <= 32'd0;
      htrans_q      <= C_TRANS_IDLE;
      issued_q      <= 17'd0;
      len_q         <= 16'd0;
      pending_q     <= 1'b0;
      rdata_q       <= 32'd0;
      rdata_valid_q <= 1'b0;
      row_done_q    <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      rdata_valid_q <= 1'b0;
      row_done_q    <= 1'b0;
      if (data_ok_d) begin
        rdata_q       <= HRDATA;
        rdata_valid_q <= 1'b1;
      end
      // An error response cancels the address currently on the bus.
      if (data_err_d) begin
        htrans_q  <= C_TRANS_IDLE;
        pending_q <= 1'b0;
        error_q   <= 1'b1;
        state_q   <= HREADY ? S_IDLE : S_ERR;
      end else begin
        case (state_q)
          S_IDLE: begin
            htrans_q <= C_TRANS_IDLE;
            if (row_start) begin
              error_q  <= 1'b0;
              issued_q <= 17'd0;
              len_q    <= length;
              if (length == 16'd0) begin
                state_q <= S_DONE;
              end else begin
                addr_q   <= start_addr_r;
                htrans_q <= C_TRANS_NONSEQ;
                state_q  <= S_BURST;
              end
            end
          end
          S_BURST: begin
            if (HREADY) begin
              pending_q <= 1'b1;
              issued_q  <= issued_d;
              if (last_addr_d) begin
                htrans_q <= C_TRANS_IDLE;
                state_q  <= S_LAST_DATA;
              end else begin
                addr_q   <= addr_d;
                htrans_q <= (addr_d[9:0] == 10'd0) ? C_TRANS_NONSEQ : C_TRANS_SEQ;
              end
            end
          end
          S_LAST_DATA: begin
            if (HREADY) begin
              pending_q <= 1'b0;
              state_q   <= S_DONE;
            end
          end
          S_DONE: begin
            row_done_q <= 1'b1;
            state_q    <= S_IDLE;
          end
          S_ERR: begin
            if (HREADY) begin
              state_q <= S_IDLE;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign HADDR         = addr_q;
  assign HTRANS        = htrans_q;
  assign HBURST        = 3'b001;
  assign HSIZE         = 3'b010;
  assign HWRITE        = 1'b0;
  assign rdata         = rdata_q;
  assign rdata_valid   = rdata_valid_q;
  assign addr_enable_r = row_done_q;
  assign row_done      = row_done_q;
  assign busy          = (state_q != S_IDLE);
  assign error         = error_q;

endmodule

`default_nettype wire

// File: tb/tb_ahb_row_reader.sv
// +--------------------------------------------------------------------------+
// | tb_ahb_row_reader : directed bench for ahb_row_reader with AHB slave     |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_ahb_row_reader;

  logic        HCLK;
  logic        HRESET;
  logic        row_start;
  logic [31:0] start_addr_r;
  logic [15:0] length;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HBURST;
  logic [2:0]  HSIZE;
  logic        HWRITE;
  logic        HREADY;
  logic        HRESP;
  logic [31:0] HRDATA;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        addr_enable_r;
  logic        row_done;
  logic        busy;
  logic        error;

  int total = 0;
  int bad   = 0;

  ahb_row_reader dut (
    .HCLK          (HCLK),
    .HRESET        (HRESET),
    .row_start     (row_start),
    .start_addr_r  (start_addr_r),
    .length        (length),
    .HADDR         (HADDR),
    .HTRANS        (HTRANS),
    .HBURST        (HBURST),
    .HSIZE         (HSIZE),
    .HWRITE        (HWRITE),
    .HREADY        (HREADY),
    .HRESP         (HRESP),
    .HRDATA        (HRDATA),
    .rdata         (rdata),
    .rdata_valid   (rdata_valid),
    .addr_enable_r (addr_enable_r),
    .row_done      (row_done),
    .busy          (busy),
    .error         (error)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  typedef struct packed {
    logic        rs;
    logic [31:0] addr;
    logic [15:0] len;
    logic [31:0] hrdata;
    logic [31:0] e_haddr;
    logic [1:0]  e_htrans;
    logic        e_rv;
    logic [31:0] e_rdata;
    logic        e_done;
    logic        e_busy;
    logic        e_err;
  } vec_t;

  vec_t vt [9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] slave_word(input logic [31:0] x);
    return {x[15:0], ~x[15:0]} ^ 32'h5A5A_0000;
  endfunction

  // Drives one row through a behavioural AHB slave and scores the bus and data side.
  task automatic run_row(input logic [31:0] a, input logic [15:0] n, input int stall_w,
                         input int stall_n, input int err_w, input int exp_nonseq,
                         input int exp_done_cyc);
    int nacc = 0, nval = 0, ndone = 0, nnonseq = 0, nactive = 0;
    int dpw = -1, stall_left = stall_n, err_ph = 0, done_at = -1;
    logic saw_busy = 1'b0, fin = 1'b0;
    logic [31:0] p_haddr, ea;
    logic [1:0]  p_htrans;
    logic        p_hready, p_hresp;
    row_start = 1'b1; start_addr_r = a; length = n;
    HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'hDEAD_BEEF;
    p_haddr = HADDR; p_htrans = HTRANS; p_hready = 1'b1; p_hresp = 1'b0;
    @(posedge HCLK); #1;
    row_start = 1'b0;
    for (int cyc = 1; cyc < 200 && !fin; cyc++) begin
      if (cyc == 1) chk("error_cleared_on_start", error, 0);
      if (HTRANS != 2'b00) nactive++;
      if (busy) saw_busy = 1'b1;
      if (rdata_valid) begin
        chk($sformatf("rdata[%0d]", nval), rdata, slave_word(a + 4 * nval));
        nval++;
      end
      if (row_done) begin
        ndone++;
        if (done_at < 0) done_at = cyc;
        chk("addr_enable_with_row_done", addr_enable_r, 1);
      end
      if (p_hready) begin
        if (p_htrans != 2'b00) begin
          ea = a + 4 * nacc;
          chk($sformatf("haddr[%0d]", nacc), p_haddr, ea);
          chk($sformatf("htrans[%0d]", nacc), p_htrans,
              (nacc == 0 || ea[9:0] == 10'd0) ? 2'b10 : 2'b11);
          if (p_htrans == 2'b10) nnonseq++;
          dpw = nacc;
          nacc++;
        end else begin
          dpw = -1;
        end
      end else if (!p_hresp && p_htrans != 2'b00) begin
        chk("haddr_held_in_wait", HADDR, p_haddr);
        chk("htrans_held_in_wait", HTRANS, p_htrans);
      end
      if (p_hresp && !p_hready) begin
        chk("htrans_cancel_after_error", HTRANS, 2'b00);
        chk("error_set", error, 1);
      end
      if (saw_busy && !busy) fin = 1'b1;
      p_haddr = HADDR; p_htrans = HTRANS;
      HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'hDEAD_BEEF;
      if (dpw >= 0) begin
        if (dpw == err_w) begin
          HREADY = (err_ph == 1);
          HRESP  = 1'b1;
          err_ph++;
        end else if (dpw == stall_w && stall_left > 0) begin
          HREADY = 1'b0;
          stall_left--;
        end else begin
          HRDATA = slave_word(a + 4 * dpw);
        end
      end
      p_hready = HREADY; p_hresp = HRESP;
      @(posedge HCLK); #1;
    end
    HREADY = 1'b1; HRESP = 1'b0;
    chk("row_finished_in_budget", fin, 1);
    chk("rdata_valid_count", nval, (err_w < 0) ? n : err_w);
    chk("row_done_count", ndone, (err_w < 0) ? 1 : 0);
    chk("accepted_addr_count", nacc, (err_w < 0) ? n : err_w + 1);
    chk("error_at_end", error, (err_w >= 0));
    chk("nonseq_count", nnonseq, exp_nonseq);
    if (n == 0) chk("no_bus_activity", nactive, 0);
    if (exp_done_cyc >= 0) chk("row_done_latency", done_at, exp_done_cyc);
  endtask

  initial begin
    // rs addr len hrdata | haddr htrans rv rdata done busy err
    vt[0] = '{1'b1, 32'h1000, 16'd4, 32'h0,         32'h0,    2'b00, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0};
    vt[1] = '{1'b0, 32'h1000, 16'd4, 32'h0,         32'h1000, 2'b10, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0};
    vt[2] = '{1'b0, 32'hDEAD0000, 16'd9, 32'h11111111, 32'h1004, 2'b11, 1'b0, 32'h0,      1'b0, 1'b1, 1'b0};
    vt[3] = '{1'b1, 32'hDEAD0000, 16'd9, 32'h22222222, 32'h1008, 2'b11, 1'b1, 32'h11111111, 1'b0, 1'b1, 1'b0};
    vt[4] = '{1'b0, 32'h1000, 16'd4, 32'h33333333, 32'h100C, 2'b11, 1'b1, 32'h22222222, 1'b0, 1'b1, 1'b0};
    vt[5] = '{1'b0, 32'h1000, 16'd4, 32'h44444444, 32'h100C, 2'b00, 1'b1, 32'h33333333, 1'b0, 1'b1, 1'b0};
    vt[6] = '{1'b0, 32'h1000, 16'd4, 32'h0,         32'h100C, 2'b00, 1'b1, 32'h44444444, 1'b0, 1'b1, 1'b0};
    vt[7] = '{1'b0, 32'h1000, 16'd4, 32'h0,         32'h100C, 2'b00, 1'b0, 32'h44444444, 1'b1, 1'b0, 1'b0};
    vt[8] = '{1'b0, 32'h1000, 16'd4, 32'h0,         32'h100C, 2'b00, 1'b0, 32'h44444444, 1'b0, 1'b0, 1'b0};

    HRESET = 1'b1; row_start = 1'b0; start_addr_r = 32'h0; length = 16'd0;
    HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'h0;
    repeat (3) @(posedge HCLK);
    #1;
    HRESET = 1'b0;
    chk("hburst", HBURST, 3'b001);
    chk("hsize", HSIZE, 3'b010);
    chk("hwrite", HWRITE, 1'b0);

    for (int i = 0; i < 9; i++) begin
      chk($sformatf("v%0d haddr", i), HADDR, vt[i].e_haddr);
      chk($sformatf("v%0d htrans", i), HTRANS, vt[i].e_htrans);
      chk($sformatf("v%0d rdata_valid", i), rdata_valid, vt[i].e_rv);
      chk($sformatf("v%0d rdata", i), rdata, vt[i].e_rdata);
      chk($sformatf("v%0d row_done", i), row_done, vt[i].e_done);
      chk($sformatf("v%0d addr_enable", i), addr_enable_r, vt[i].e_done);
      chk($sformatf("v%0d busy", i), busy, vt[i].e_busy);
      chk($sformatf("v%0d error", i), error, vt[i].e_err);
      row_start = vt[i].rs; start_addr_r = vt[i].addr; length = vt[i].len;
      HREADY = 1'b1; HRESP = 1'b0; HRDATA = vt[i].hrdata;
      @(posedge HCLK); #1;
    end

    run_row(32'h1000, 16'd4, 1, 2, -1, 1, 9);
    run_row(32'h13F8, 16'd4, -1, 0, -1, 2, 7);
    run_row(32'h1000, 16'd0, -1, 0, -1, 0, 2);
    run_row(32'h1000, 16'd4, -1, 0, 1, 1, -1);
    repeat (3) @(posedge HCLK);
    #1;
    chk("error_sticky", error, 1);
    chk("no_row_done_after_abort", row_done, 0);
    run_row(32'h4000, 16'd3, -1, 0, -1, 1, 6);

    // Reset in the middle of an 8-word row, with the third word on the bus.
    row_start = 1'b1; start_addr_r = 32'h3000; length = 16'd8;
    HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'h0;
    @(posedge HCLK); #1;
    row_start = 1'b0;
    @(posedge HCLK); #1;
    HRDATA = 32'hCAFE_F00D;
    @(posedge HCLK); #1;
    chk("pre_reset_haddr", HADDR, 32'h3008);
    chk("pre_reset_rdata", rdata, 32'hCAFE_F00D);
    HRESET = 1'b1;
    @(posedge HCLK); #1;
    HRESET = 1'b0;
    chk("rst haddr", HADDR, 0);
    chk("rst htrans", HTRANS, 0);
    chk("rst rdata", rdata, 0);
    chk("rst rdata_valid", rdata_valid, 0);
    chk("rst row_done", row_done, 0);
    chk("rst addr_enable", addr_enable_r, 0);
    chk("rst busy", busy, 0);
    chk("rst error", error, 0);
    run_row(32'h2000, 16'd4, -1, 0, -1, 1, 7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
